// File: rtl/sd_pkg.sv
// Shared SD SPI-mode definitions: command frames, R1 codes and init error codes.
// Used by the init sequencer and by the read/write controllers.
package sd_pkg;

    typedef struct packed {
        logic [7:0]  number;
        logic [31:0] args;
        logic [7:0]  crc;
    } sd_cmd_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_CMD0    = 3'd1,
        ERR_CMD8    = 3'd2,
        ERR_ACMD41  = 3'd3,
        ERR_CMD58   = 3'd4,
        ERR_TIMEOUT = 3'd5
    } sd_err_e;

    localparam logic [7:0]  R1_READY  = 8'h00;
    localparam logic [7:0]  R1_IDLE   = 8'h01;
    localparam logic [11:0] CMD8_ECHO = 12'h1AA;

    // Command byte on the wire: start bit 0, transmission bit 1, 6-bit index.
    function automatic logic [7:0] sd_cmd_byte(input logic [5:0] index);
        return {2'b01, index};
    endfunction

    localparam sd_cmd_t SD_CMD_NONE = '0;
    localparam sd_cmd_t SD_CMD0 = '{number: sd_cmd_byte(6'd0),  args: 32'h0000_0000, crc: 8'h95};
    localparam sd_cmd_t SD_CMD8 = '{number: sd_cmd_byte(6'd8),  args: 32'h0000_01AA, crc: 8'h87};
    localparam sd_cmd_t SD_CMD55 = '{number: sd_cmd_byte(6'd55), args: 32'h0000_0000, crc: 8'h65};
    localparam sd_cmd_t SD_ACMD41 = '{number: sd_cmd_byte(6'd41), args: 32'h4000_0000, crc: 8'h77};
    localparam sd_cmd_t SD_CMD58 = '{number: sd_cmd_byte(6'd58), args: 32'h0000_0000, crc: 8'hFD};

endpackage

// File: rtl/sd_init_seq.sv
// SD card SPI-mode power-up sequencer: dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
// Drives a separate command engine through the cmd_* ports.
module sd_init_seq
    import sd_pkg::*;
#(
    parameter int DUMMY_CYCLES   = 80,
    parameter int ACMD41_RETRIES = 1000,
    parameter int CMD_TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_start,
    output logic        init_done,
    output logic        init_error,
    output logic [2:0]  error_code,
    output logic [7:0]  cmd_number,
    output logic [31:0] cmd_args,
    output logic [7:0]  cmd_crc,
    output logic        cmd_start,
    input  logic        cmd_done,
    input  logic [7:0]  response_flags,
    output logic        CS,
    output logic        high_capacity,
    input  logic [31:0] ocr,
    output logic [3:0]  dbg_state
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_DUMMY  = 4'd1;
    localparam logic [3:0] ST_CMD0   = 4'd2;
    localparam logic [3:0] ST_CMD8   = 4'd3;
    localparam logic [3:0] ST_CMD55  = 4'd4;
    localparam logic [3:0] ST_ACMD41 = 4'd5;
    localparam logic [3:0] ST_CMD58  = 4'd6;
    localparam logic [3:0] ST_GAP    = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;
    localparam logic [3:0] ST_ERROR  = 4'd9;

    localparam int DW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
    localparam int RW = (ACMD41_RETRIES > 1) ? $clog2(ACMD41_RETRIES) : 1;
    localparam int TW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;

    localparam logic [DW-1:0] DUMMY_LAST = DW'(DUMMY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(ACMD41_RETRIES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(CMD_TIMEOUT - 1);

    logic [3:0]    state_q, state_d;
    logic [3:0]    resume_q, resume_d;
    logic [DW-1:0] dummy_cnt_q, dummy_cnt_d;
    logic [RW-1:0] retry_cnt_q, retry_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    sd_err_e       err_q, err_d;
    logic          hc_q, hc_d;

    logic          in_cmd;
    logic [3:0]    judge_next;
    sd_err_e       judge_err;
    logic          judge_retry;
    sd_cmd_t       frame;

    logic          unused_ocr_bits;
    assign unused_ocr_bits = ^{ocr[31], ocr[29:12]};

    assign in_cmd = (state_q == ST_CMD0) || (state_q == ST_CMD8) || (state_q == ST_CMD55) ||
                    (state_q == ST_ACMD41) || (state_q == ST_CMD58);

    // Verdict on the R1/OCR presented with cmd_done in the current command state.
    always_comb begin
        judge_next  = ST_ERROR;
        judge_err   = ERR_NONE;
        judge_retry = 1'b0;
        case (state_q)
            ST_CMD0: begin
                if (response_flags == R1_IDLE) judge_next = ST_CMD8;
                else                           judge_err  = ERR_CMD0;
            end
            ST_CMD8: begin
                if (response_flags == R1_IDLE && ocr[11:0] == CMD8_ECHO) judge_next = ST_CMD55;
                else                                                      judge_err  = ERR_CMD8;
            end
            ST_CMD55: begin
                if (!response_flags[7]) judge_next = ST_ACMD41;
                else                    judge_err  = ERR_ACMD41;
            end
            ST_ACMD41: begin
                if (response_flags == R1_READY) begin
                    judge_next = ST_CMD58;
                end else if (response_flags == R1_IDLE && retry_cnt_q != RETRY_LAST) begin
                    judge_next  = ST_CMD55;
                    judge_retry = 1'b1;
                end else begin
                    judge_err = ERR_ACMD41;
                end
            end
            ST_CMD58: begin
                if (response_flags == R1_READY) judge_next = ST_DONE;
                else                            judge_err  = ERR_CMD58;
            end
            default: judge_next = ST_ERROR;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        dummy_cnt_d = dummy_cnt_q;
        retry_cnt_d = retry_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
        hc_d        = hc_q;
        if (!init_start) begin
            state_d     = ST_IDLE;
            resume_d    = ST_IDLE;
            dummy_cnt_d = '0;
            retry_cnt_d = '0;
            tmo_cnt_d   = '0;
            err_d       = ERR_NONE;
            hc_d        = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_DUMMY;
                    dummy_cnt_d = '0;
                    retry_cnt_d = '0;
                    tmo_cnt_d   = '0;
                    err_d       = ERR_NONE;
                    hc_d        = 1'b0;
                end
                ST_DUMMY: begin
                    if (dummy_cnt_q == DUMMY_LAST) begin
                        state_d   = ST_CMD0;
                        tmo_cnt_d = '0;
                    end else begin
                        dummy_cnt_d = dummy_cnt_q + 1'b1;
                    end
                end
                ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD58: begin
                    if (cmd_done) begin
                        state_d   = ST_GAP;
                        resume_d  = judge_next;
                        tmo_cnt_d = '0;
                        if (judge_next == ST_ERROR) err_d = judge_err;
                        if (judge_retry) retry_cnt_d = retry_cnt_q + 1'b1;
                        if (judge_next == ST_DONE) hc_d = ocr[30];
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_d   = resume_q;
                    tmo_cnt_d = '0;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            resume_q    <= ST_IDLE;
            dummy_cnt_q <= '0;
            retry_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            err_q       <= ERR_NONE;
            hc_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            dummy_cnt_q <= dummy_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
            hc_q        <= hc_d;
        end
    end

    always_comb begin
        frame = SD_CMD_NONE;
        case (state_q)
            ST_CMD0:   frame = SD_CMD0;
            ST_CMD8:   frame = SD_CMD8;
            ST_CMD55:  frame = SD_CMD55;
            ST_ACMD41: frame = SD_ACMD41;
            ST_CMD58:  frame = SD_CMD58;
            default:   frame = SD_CMD_NONE;
        endcase
    end

    // Engine handshake: cmd_start is a level request held with a stable frame until
    // cmd_done is sampled high; the GAP cycle then drops it so every command has a fresh rising edge.
    // Gating with init_start lets an abort release the engine and the card in the same cycle.
    assign cmd_start     = in_cmd & init_start;
    assign CS            = ~((in_cmd | (state_q == ST_GAP)) & init_start);
    assign cmd_number    = frame.number;
    assign cmd_args      = frame.args;
    assign cmd_crc       = frame.crc;
    assign init_done     = (state_q == ST_DONE);
    assign init_error    = (state_q == ST_ERROR);
    assign error_code    = (state_q == ST_ERROR) ? err_q : ERR_NONE;
    assign high_capacity = hc_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// Randomised card/engine model driving sd_init_seq, checked against a
// response-script reference model of the init sequence.
module tb_sd_init_seq;

    localparam int DUMMY   = 80;
    localparam int RETRIES = 4;
    localparam int TMO     = 16;
    localparam int BUDGET  = 3000;

    typedef struct {
        int         bad;      // 0 none, 1 CMD0, 2 CMD8 echo, 3 CMD55 bit7, 4 ACMD41 other, 5 CMD58
        int         n_idle;   // ACMD41 0x01 replies before 0x00
        logic       ocr30;
        logic [7:0] silent;   // command the engine never completes (0 = none)
        int         lat_max;
    } scn_t;

    logic        clk = 1'b0;
    logic        reset, init_start, cmd_done;
    logic [7:0]  response_flags;
    logic [31:0] ocr;
    logic        init_done, init_error, cmd_start, CS, high_capacity;
    logic [2:0]  error_code;
    logic [7:0]  cmd_number, cmd_crc;
    logic [31:0] cmd_args;
    logic [3:0]  dbg_state;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    sd_init_seq #(.DUMMY_CYCLES(DUMMY), .ACMD41_RETRIES(RETRIES), .CMD_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .init_start(init_start),
        .init_done(init_done), .init_error(init_error), .error_code(error_code),
        .cmd_number(cmd_number), .cmd_args(cmd_args), .cmd_crc(cmd_crc),
        .cmd_start(cmd_start), .cmd_done(cmd_done), .response_flags(response_flags),
        .CS(CS), .high_capacity(high_capacity), .ocr(ocr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] exp_frame(input logic [7:0] num);
        case (num)
            8'h40:   return {32'h0000_0000, 8'h95};
            8'h48:   return {32'h0000_01AA, 8'h87};
            8'h77:   return {32'h0000_0000, 8'h65};
            8'h69:   return {32'h4000_0000, 8'h77};
            8'h7A:   return {32'h0000_0000, 8'hFD};
            default: return 40'hFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic bit issue(input logic [7:0] c, input logic [7:0] silent);
        exp_q.push_back(c);
        return (c == silent);
    endfunction

    // Expected command list and outcome, walked straight from the response script.
    function automatic void model(input scn_t s, output logic m_done, output logic [2:0] m_code,
                                  output logic m_hc);
        exp_q.delete();
        m_done = 1'b0;
        m_code = 3'd0;
        m_hc   = 1'b0;
        if (issue(8'h40, s.silent)) begin m_code = 3'd5; return; end
        if (s.bad == 1) begin m_code = 3'd1; return; end
        if (issue(8'h48, s.silent)) begin m_code = 3'd5; return; end
        if (s.bad == 2) begin m_code = 3'd2; return; end
        for (int p = 0; p < 64; p++) begin
            if (issue(8'h77, s.silent)) begin m_code = 3'd5; return; end
            if (s.bad == 3) begin m_code = 3'd3; return; end
            if (issue(8'h69, s.silent)) begin m_code = 3'd5; return; end
            if (p >= s.n_idle) break;
            if (p + 1 >= RETRIES) begin m_code = 3'd3; return; end
        end
        if (s.bad == 4) begin m_code = 3'd3; return; end
        if (issue(8'h7A, s.silent)) begin m_code = 3'd5; return; end
        if (s.bad == 5) begin m_code = 3'd4; return; end
        m_done = 1'b1;
        m_hc   = s.ocr30;
    endfunction

    function automatic void card_reply(input scn_t s, input logic [7:0] num, input int acmd_idx,
                                       output logic [7:0] r, output logic [31:0] o);
        o = $urandom;
        case (num)
            8'h40: r = (s.bad == 1) ? 8'($urandom_range(2, 255)) : 8'h01;
            8'h48: begin
                r = 8'h01;
                o = {o[31:12], (s.bad == 2) ? 12'h1AB : 12'h1AA};
            end
            8'h77: r = (s.bad == 3) ? (8'h80 | 8'($urandom_range(0, 127))) : 8'($urandom_range(0, 127));
            8'h69: r = (acmd_idx < s.n_idle) ? 8'h01 : ((s.bad == 4) ? 8'h05 : 8'h00);
            8'h7A: begin
                r = (s.bad == 5) ? 8'h01 : 8'h00;
                o = s.ocr30 ? 32'hC0FF_8000 : 32'h80FF_8000;
            end
            default: r = 8'hFF;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_cs"}, CS, 1'b1);
        check_eq({tag, "_start"}, cmd_start, 1'b0);
        check_eq({tag, "_flags"}, {init_done, init_error, error_code, high_capacity}, 6'd0);
        check_eq({tag, "_num"}, cmd_number, 8'h00);
    endtask

    // abort_mode: 0 run to completion, 1 reset at first CMD55, 2 drop init_start at first ACMD41.
    task automatic run_scn(input scn_t s, input int abort_mode);
        logic       m_done, m_hc;
        logic [2:0] m_code;
        logic [7:0] got_q[$];
        logic [47:0] cur;
        logic [39:0] ef;
        logic [7:0] r;
        logic [31:0] o;
        int cs_cnt, start_cs, both, unstable, silent_cyc, acmd_n, lat, lat_cnt, cyc;
        bit first, prev, finished;
        cs_cnt = 0; start_cs = 0; both = 0; unstable = 0; silent_cyc = 0;
        acmd_n = 0; lat = 0; lat_cnt = 0; cyc = 0;
        first = 0; prev = 0; finished = 0; cur = '0;
        model(s, m_done, m_code, m_hc);
        @(negedge clk);
        init_start = 1'b1;
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            cmd_done = 1'b0;
            if (CS && cmd_start) start_cs++;
            if (init_done && init_error) both++;
            if (!first && CS) cs_cnt++;
            if (init_done || init_error) begin
                finished = 1;
                break;
            end
            if (cmd_start) begin
                first = 1;
                if (!prev) begin
                    got_q.push_back(cmd_number);
                    cur = {cmd_number, cmd_args, cmd_crc};
                    ef  = exp_frame(cmd_number);
                    check_eq("cmd_args", cmd_args, ef[39:8]);
                    check_eq("cmd_crc", cmd_crc, ef[7:0]);
                    if (cmd_number == 8'h69) acmd_n++;
                    lat = $urandom_range(0, s.lat_max);
                    lat_cnt = 0;
                    if (abort_mode == 1 && cmd_number == 8'h77) begin
                        reset = 1'b1;
                        #1;
                        check_eq("rst_abort_start", cmd_start, 1'b0);
                        check_eq("rst_abort_cs", CS, 1'b1);
                        init_start = 1'b0;
                        @(negedge clk);
                        reset = 1'b0;
                        @(negedge clk);
                        check_idle("rst_abort_idle");
                        return;
                    end
                    if (abort_mode == 2 && cmd_number == 8'h69) begin
                        init_start = 1'b0;
                        #1;
                        check_eq("drop_abort_start", cmd_start, 1'b0);
                        check_eq("drop_abort_cs", CS, 1'b1);
                        @(negedge clk);
                        check_idle("drop_abort_idle");
                        return;
                    end
                end else if ({cmd_number, cmd_args, cmd_crc} != cur) begin
                    unstable++;
                end
                if (cmd_number == s.silent) begin
                    silent_cyc++;
                end else if (lat_cnt == lat) begin
                    card_reply(s, cmd_number, acmd_n - 1, r, o);
                    response_flags = r;
                    ocr = o;
                    cmd_done = 1'b1;
                    lat_cnt++;
                end else begin
                    lat_cnt++;
                end
            end
            prev = cmd_start;
        end
        check_eq("seq_finished", finished, 1'b1);
        check_eq("dummy_cs_cycles", cs_cnt, DUMMY);
        check_eq("n_cmds", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq("cmd_seq", got_q[i], exp_q[i]);
        check_eq("init_done", init_done, m_done);
        check_eq("init_error", init_error, !m_done);
        check_eq("error_code", error_code, m_code);
        check_eq("high_capacity", high_capacity, m_hc);
        check_eq("end_cs", CS, 1'b1);
        check_eq("start_while_cs", start_cs, 0);
        check_eq("done_and_error", both, 0);
        check_eq("frame_unstable", unstable, 0);
        if (m_code == 3'd5) check_eq("timeout_cycles", silent_cyc, TMO);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("hold_start", cmd_start, 1'b0);
            check_eq("hold_cs", CS, 1'b1);
            check_eq("hold_flags", {init_done, init_error, error_code}, {m_done, !m_done, m_code});
        end
        init_start = 1'b0;
        @(negedge clk);
        check_idle("release_idle");
    endtask

    function automatic scn_t mk(input int bad, input int n_idle, input logic ocr30,
                                input logic [7:0] silent);
        scn_t s;
        s.bad = bad;
        s.n_idle = n_idle;
        s.ocr30 = ocr30;
        s.silent = silent;
        s.lat_max = $urandom_range(0, 4);
        return s;
    endfunction

    initial begin
        logic [7:0] cmds[5];
        scn_t s;
        cmds = '{8'h40, 8'h48, 8'h77, 8'h69, 8'h7A};
        reset = 1'b1;
        init_start = 1'b0;
        cmd_done = 1'b0;
        response_flags = 8'h00;
        ocr = 32'h0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);

        run_scn(mk(0, 0, 1'b1, 8'h00), 0);   // nominal high-capacity card
        run_scn(mk(0, 3, 1'b0, 8'h00), 0);   // three busy ACMD41 replies
        run_scn(mk(2, 0, 1'b1, 8'h00), 0);   // CMD8 echo mismatch
        run_scn(mk(0, 9, 1'b1, 8'h00), 0);   // ACMD41 never ready
        run_scn(mk(0, 0, 1'b1, 8'h40), 0);   // engine silent on CMD0
        run_scn(mk(1, 0, 1'b0, 8'h00), 0);
        run_scn(mk(3, 0, 1'b0, 8'h00), 0);
        run_scn(mk(4, 1, 1'b0, 8'h00), 0);
        run_scn(mk(5, 0, 1'b1, 8'h00), 0);

        run_scn(mk(0, 1, 1'b1, 8'h00), 1);
        run_scn(mk(0, 1, 1'b1, 8'h00), 0);
        run_scn(mk(0, 1, 1'b0, 8'h00), 2);
        run_scn(mk(0, 2, 1'b0, 8'h00), 0);

        for (int t = 0; t < 25; t++) begin
            s = mk($urandom_range(0, 1) ? 0 : $urandom_range(1, 5), $urandom_range(0, 5),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0) ? cmds[$urandom_range(0, 4)] : 8'h00);
            run_scn(s, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
